// File: rtl/pic_bus_master.sv
// 8259A bus initiator: turns INIT/WRITE/READ commands into
// timed CS/WR/RE/A0/D bus cycles with a one-cycle completion pulse.
module pic_bus_master #(
  parameter int STROBE_CYCLES   = 2,
  parameter int RECOVERY_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic       cmd_a0,
  input  logic [7:0] cmd_data,
  input  logic [1:0] cmd_sel,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
  output logic       CS,
  output logic       WR,
  output logic       RE,
  output logic       A0,
  output logic [7:0] D_out,
  output logic       D_oe,
  input  logic [7:0] D_in,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       init_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_RECOVER, S_DONE
  } state_t;

  localparam logic [3:0] STB_LAST = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] REC_LAST = 4'(RECOVERY_CYCLES - 1);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [1:0]      last_q, last_d;
  logic [3:0]      rdl_q, rdl_d;
  logic [3:0]      a0l_q, a0l_d;
  logic [3:0][7:0] datl_q, datl_d;
  logic            is_init_q, is_init_d;
  logic            is_rd_q, is_rd_d;
  logic            cs_q, cs_d;
  logic            wr_q, wr_d;
  logic            re_q, re_d;
  logic            a0_q, a0_d;
  logic [7:0]      dout_q, dout_d;
  logic            doe_q, doe_d;
  logic            rv_q, rv_d;
  logic [7:0]      rdat_q, rdat_d;
  logic            idone_q, idone_d;
  logic            rdy_q, rdy_d;
  logic            go_setup, go_done;
  logic [2:0]      n;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    last_d    = last_q;
    rdl_d     = rdl_q;
    a0l_d     = a0l_q;
    datl_d    = datl_q;
    is_init_d = is_init_q;
    is_rd_d   = is_rd_q;
    cs_d      = cs_q;
    wr_d      = wr_q;
    re_d      = re_q;
    a0_d      = a0_q;
    dout_d    = dout_q;
    doe_d     = doe_q;
    rv_d      = 1'b0;
    rdat_d    = rdat_q;
    idone_d   = idone_q;
    rdy_d     = rdy_q;
    go_setup  = 1'b0;
    go_done   = 1'b0;
    n         = 3'd0;

    unique case (state_q)
      S_SETUP: begin
        state_d = S_STROBE;
        cnt_d   = STB_LAST;
        wr_d    = rdl_q[idx_q];
        re_d    = !rdl_q[idx_q];
      end
      S_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_HOLD;
          wr_d    = 1'b1;
          re_d    = 1'b1;
          if (rdl_q[idx_q]) rdat_d = D_in;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        state_d = S_RECOVER;
        cs_d    = 1'b1;
        doe_d   = 1'b0;
        cnt_d   = REC_LAST;
      end
      S_RECOVER: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (idx_q == last_q) begin
          go_done = 1'b1;
        end else begin
          idx_d    = idx_q + 2'd1;
          go_setup = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: ;
    endcase

    // Accept: build the whole bus-cycle list from the sampled fields
    if (rdy_q && cmd_valid) begin
      rdy_d     = 1'b0;
      rdl_d     = 4'b0000;
      a0l_d     = 4'b0000;
      datl_d    = '0;
      idx_d     = 2'd0;
      last_d    = 2'd0;
      is_init_d = (cmd_op == 2'b00);
      is_rd_d   = (cmd_op == 2'b10);
      go_setup  = 1'b1;
      unique case (cmd_op)
        2'b00: begin
          a0l_d     = 4'b1110;
          datl_d[0] = icw1 | 8'h10;
          datl_d[1] = icw2;
          n         = 3'd2;
          if (!icw1[1]) begin
            datl_d[n[1:0]] = icw3;
            n = n + 3'd1;
          end
          if (icw1[0]) begin
            datl_d[n[1:0]] = icw4;
            n = n + 3'd1;
          end
          last_d  = 2'(n - 3'd1);
          idone_d = 1'b0;
        end
        2'b01: begin
          a0l_d[0]  = cmd_a0;
          datl_d[0] = cmd_data;
        end
        2'b10: begin
          if (cmd_sel[1]) begin
            rdl_d = 4'b0001;
            a0l_d = 4'b0001;
          end else begin
            rdl_d     = 4'b0010;
            datl_d[0] = {7'h05, cmd_sel[0]};
            last_d    = 2'd1;
          end
        end
        default: begin
          go_setup = 1'b0;
          go_done  = 1'b1;
        end
      endcase
    end

    if (go_setup) begin
      state_d = S_SETUP;
      cs_d    = 1'b0;
      a0_d    = a0l_d[idx_d];
      dout_d  = datl_d[idx_d];
      doe_d   = !rdl_d[idx_d];
    end
    if (go_done) begin
      state_d = S_DONE;
      rv_d    = 1'b1;
      rdy_d   = 1'b1;
      if (is_init_d) idone_d = 1'b1;
      if (!is_rd_d) rdat_d = 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= 2'd0;
      last_q    <= 2'd0;
      rdl_q     <= 4'b0000;
      a0l_q     <= 4'b0000;
      datl_q    <= '0;
      is_init_q <= 1'b0;
      is_rd_q   <= 1'b0;
      cs_q      <= 1'b1;
      wr_q      <= 1'b1;
      re_q      <= 1'b1;
      a0_q      <= 1'b0;
      dout_q    <= 8'h00;
      doe_q     <= 1'b0;
      rv_q      <= 1'b0;
      rdat_q    <= 8'h00;
      idone_q   <= 1'b0;
      rdy_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      rdl_q     <= rdl_d;
      a0l_q     <= a0l_d;
      datl_q    <= datl_d;
      is_init_q <= is_init_d;
      is_rd_q   <= is_rd_d;
      cs_q      <= cs_d;
      wr_q      <= wr_d;
      re_q      <= re_d;
      a0_q      <= a0_d;
      dout_q    <= dout_d;
      doe_q     <= doe_d;
      rv_q      <= rv_d;
      rdat_q    <= rdat_d;
      idone_q   <= idone_d;
      rdy_q     <= rdy_d;
    end
  end

  assign cmd_ready = rdy_q;
  assign CS        = cs_q;
  assign WR        = wr_q;
  assign RE        = re_q;
  assign A0        = a0_q;
  assign D_out     = dout_q;
  assign D_oe      = doe_q;
  assign rsp_valid = rv_q;
  assign rsp_data  = rdat_q;
  assign init_done = idone_q;

endmodule

// File: tb/tb_pic_bus_master.sv
// Bench for pic_bus_master: per-cycle timeline model plus
// directed literal checks and a randomized command stream.
module tb_pic_bus_master;

  localparam int S = 2;
  localparam int R = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic       cmd_a0 = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic [1:0] cmd_sel = 2'b00;
  logic [7:0] icw1 = 8'h00, icw2 = 8'h00;
  logic [7:0] icw3 = 8'h00, icw4 = 8'h00;
  logic       CS, WR, RE, A0, D_oe;
  logic [7:0] D_out;
  logic [7:0] D_in = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       init_done;

  always #5 clk = ~clk;

  pic_bus_master #(
    .STROBE_CYCLES(S),
    .RECOVERY_CYCLES(R)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a0(cmd_a0),
    .cmd_data(cmd_data), .cmd_sel(cmd_sel),
    .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
    .CS(CS), .WR(WR), .RE(RE), .A0(A0),
    .D_out(D_out), .D_oe(D_oe), .D_in(D_in),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .init_done(init_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected per-cycle view of the bus and response outputs
  typedef struct packed {
    logic       cs, wr, re, a0;
    logic [7:0] d;
    logic       doe, chk_ad, rv, rdy, cap, clr_rsp, set_init, clr_init;
  } snap_t;

  typedef struct packed {
    logic       rd;
    logic       a0;
    logic [7:0] d;
  } bus_t;

  snap_t      q[$];
  logic [7:0] exp_rsp = 8'h00;
  logic       exp_init = 1'b0;

  function automatic snap_t idle_snap();
    snap_t s;
    s = '0;
    s.cs = 1'b1; s.wr = 1'b1; s.re = 1'b1; s.rdy = 1'b1;
    return s;
  endfunction

  function automatic void plan(input logic [1:0] op, input logic a0,
                               input logic [7:0] dat, input logic [1:0] sel,
                               input logic [7:0] i1, input logic [7:0] i2,
                               input logic [7:0] i3, input logic [7:0] i4);
    bus_t  lst[$];
    snap_t s;
    case (op)
      2'b00: begin
        lst.push_back('{1'b0, 1'b0, i1 | 8'h10});
        lst.push_back('{1'b0, 1'b1, i2});
        if (!i1[1]) lst.push_back('{1'b0, 1'b1, i3});
        if (i1[0]) lst.push_back('{1'b0, 1'b1, i4});
      end
      2'b01: lst.push_back('{1'b0, a0, dat});
      2'b10: begin
        if (sel[1]) lst.push_back('{1'b1, 1'b1, 8'h00});
        else begin
          lst.push_back('{1'b0, 1'b0, 8'h0A + {7'd0, sel[0]}});
          lst.push_back('{1'b1, 1'b0, 8'h00});
        end
      end
      default: ;
    endcase
    foreach (lst[i]) begin
      s = idle_snap();
      s.rdy = 1'b0; s.cs = 1'b0;
      s.a0 = lst[i].a0; s.d = lst[i].d;
      s.doe = !lst[i].rd; s.chk_ad = 1'b1;
      s.clr_init = (i == 0) && (op == 2'b00);
      q.push_back(s);
      s.clr_init = 1'b0;
      for (int j = 0; j < S; j++) begin
        s.wr = lst[i].rd;
        s.re = !lst[i].rd;
        s.cap = lst[i].rd && (j == S - 1);
        q.push_back(s);
      end
      s.wr = 1'b1; s.re = 1'b1; s.cap = 1'b0;
      q.push_back(s);
      for (int j = 0; j < R; j++) begin
        s.cs = 1'b1; s.doe = 1'b0; s.chk_ad = 1'b0;
        q.push_back(s);
      end
    end
    s = idle_snap();
    s.rv = 1'b1;
    s.set_init = (op == 2'b00);
    s.clr_rsp = (op != 2'b10);
    q.push_back(s);
  endfunction

  int         cyc = 0;
  always @(posedge clk) cyc++;

  logic       din_fix = 1'b0;
  logic [7:0] din_val = 8'h00;
  always @(posedge clk) begin
    #1;
    D_in = din_fix ? din_val : 8'($urandom);
  end

  logic [8:0] wr_log[$];
  logic [1:0] re_log[$];
  logic       wr_prev = 1'b1, re_prev = 1'b1, cs_prev = 1'b1;
  int         acc_cyc = 0, last_lat = -1;
  int         cs_hi_run = 0, last_gap = -1;
  snap_t      cs_s;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      exp_rsp = 8'h00;
      exp_init = 1'b0;
      chk("reset_ctl", 32'({CS, WR, RE, D_oe, rsp_valid, cmd_ready}),
          32'(6'b111001));
      chk("reset_rsp_data", 32'(rsp_data), 32'h0);
      chk("reset_init_done", 32'(init_done), 32'h0);
    end else begin
      cs_s = (q.size() > 0) ? q.pop_front() : idle_snap();
      if (cs_s.clr_init) exp_init = 1'b0;
      if (cs_s.set_init) exp_init = 1'b1;
      if (cs_s.clr_rsp) exp_rsp = 8'h00;
      chk("cs_wr_re_oe_rv_rdy",
          32'({CS, WR, RE, D_oe, rsp_valid, cmd_ready}),
          32'({cs_s.cs, cs_s.wr, cs_s.re, cs_s.doe, cs_s.rv, cs_s.rdy}));
      chk("rsp_data", 32'(rsp_data), 32'(exp_rsp));
      chk("init_done", 32'(init_done), 32'(exp_init));
      if (cs_s.chk_ad) chk("a0", 32'(A0), 32'(cs_s.a0));
      if (cs_s.chk_ad && cs_s.doe) chk("d_out", 32'(D_out), 32'(cs_s.d));
      if (cs_s.cap) exp_rsp = D_in;
      if (!WR && wr_prev) wr_log.push_back({A0, D_out});
      if (!RE && re_prev) re_log.push_back({A0, D_oe});
      if (CS) cs_hi_run++;
      else begin
        if (cs_prev) last_gap = cs_hi_run;
        cs_hi_run = 0;
      end
      if (rsp_valid) last_lat = cyc - acc_cyc;
      if (cmd_valid && cmd_ready) begin
        acc_cyc = cyc;
        plan(cmd_op, cmd_a0, cmd_data, cmd_sel, icw1, icw2, icw3, icw4);
      end
    end
    wr_prev = WR;
    re_prev = RE;
    cs_prev = CS;
  end

  task automatic send(input logic [1:0] op, input logic a0,
                      input logic [7:0] dat, input logic [1:0] sel,
                      input logic [7:0] i1, input logic [7:0] i2,
                      input logic [7:0] i3, input logic [7:0] i4);
    int n;
    @(posedge clk);
    #1;
    cmd_op = op; cmd_a0 = a0; cmd_data = dat; cmd_sel = sel;
    icw1 = i1; icw2 = i2; icw3 = i3; icw4 = i4;
    cmd_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 200);
    if (!cmd_ready) chk("accept_timeout", 32'(cmd_ready), 32'h1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_a0 = 1'($urandom);
    cmd_data = 8'($urandom); cmd_sel = 2'($urandom);
    icw1 = 8'($urandom); icw2 = 8'($urandom);
    icw3 = 8'($urandom); icw4 = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(q.size() == 0 && cmd_ready) && n < 500);
    if (q.size() != 0) chk("idle_timeout", 32'(q.size()), 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_bus", 32'({CS, WR, RE, A0, D_out, D_oe}),
        32'({3'b111, 1'b0, 8'h00, 1'b0}));
    chk("rst_rsp", 32'({rsp_valid, rsp_data, init_done, cmd_ready}),
        32'({1'b0, 8'h00, 1'b0, 1'b1}));
    #20 rst_n = 1'b1;

    // single PIC with IC4: ICW3 skipped
    wr_log.delete();
    send(2'b00, 1'b0, 8'h00, 2'b00, 8'h13, 8'h20, 8'hAA, 8'h01);
    wait_idle();
    chk("t1_nwr", 32'(wr_log.size()), 32'd3);
    if (wr_log.size() == 3) begin
      chk("t1_icw1", 32'(wr_log[0]), 32'({1'b0, 8'h13}));
      chk("t1_icw2", 32'(wr_log[1]), 32'({1'b1, 8'h20}));
      chk("t1_icw4", 32'(wr_log[2]), 32'({1'b1, 8'h01}));
    end
    chk("t1_latency", 32'(last_lat), 32'd16);
    chk("t1_init_done", 32'(init_done), 32'h1);

    // cascade: ICW3 then ICW4, bit4 forced into ICW1
    wr_log.delete();
    send(2'b00, 1'b0, 8'h00, 2'b00, 8'h01, 8'h40, 8'h04, 8'h03);
    wait_idle();
    chk("t2_nwr", 32'(wr_log.size()), 32'd4);
    if (wr_log.size() == 4) begin
      chk("t2_icw1", 32'(wr_log[0]), 32'({1'b0, 8'h11}));
      chk("t2_icw2", 32'(wr_log[1]), 32'({1'b1, 8'h40}));
      chk("t2_icw3", 32'(wr_log[2]), 32'({1'b1, 8'h04}));
      chk("t2_icw4", 32'(wr_log[3]), 32'({1'b1, 8'h03}));
    end
    chk("t2_latency", 32'(last_lat), 32'd21);

    // ISR read
    wr_log.delete(); re_log.delete();
    din_fix = 1'b1; din_val = 8'h5A;
    send(2'b10, 1'b0, 8'h00, 2'b01, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_idle();
    chk("t3_nwr", 32'(wr_log.size()), 32'd1);
    if (wr_log.size() == 1) chk("t3_ocw3", 32'(wr_log[0]), 32'({1'b0, 8'h0B}));
    chk("t3_nre", 32'(re_log.size()), 32'd1);
    if (re_log.size() == 1) chk("t3_re_a0_oe", 32'(re_log[0]), 32'h0);
    chk("t3_rsp_data", 32'(rsp_data), 32'h5A);
    chk("t3_latency", 32'(last_lat), 32'd11);

    // IMR read
    wr_log.delete(); re_log.delete();
    din_val = 8'hF0;
    send(2'b10, 1'b0, 8'h00, 2'b10, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_idle();
    chk("t4_nwr", 32'(wr_log.size()), 32'd0);
    chk("t4_nre", 32'(re_log.size()), 32'd1);
    if (re_log.size() == 1) chk("t4_re_a0_oe", 32'(re_log[0]), 32'b10);
    chk("t4_rsp_data", 32'(rsp_data), 32'hF0);
    chk("t4_latency", 32'(last_lat), 32'd6);
    din_fix = 1'b0;

    // back-to-back writes, second held valid
    wr_log.delete();
    send(2'b01, 1'b1, 8'hFB, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    send(2'b01, 1'b0, 8'h55, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_idle();
    chk("t5_nwr", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) begin
      chk("t5_w0", 32'(wr_log[0]), 32'({1'b1, 8'hFB}));
      chk("t5_w1", 32'(wr_log[1]), 32'({1'b0, 8'h55}));
    end
    chk("t5_cs_gap", 32'(last_gap), 32'(R + 1));
    chk("t5_rsp_cleared", 32'(rsp_data), 32'h0);

    // reset during ICW2 strobe
    wr_log.delete();
    send(2'b00, 1'b0, 8'h00, 2'b00, 8'h13, 8'h20, 8'h00, 8'h01);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (wr_log.size() < 2 && n < 100);
    chk("t6_reach_icw2", 32'(wr_log.size()), 32'd2);
    chk("t6_in_strobe", 32'({CS, WR}), 32'b00);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_cs_wr", 32'({CS, WR, RE}), 32'b111);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_init_done_low", 32'(init_done), 32'h0);
    send(2'b00, 1'b0, 8'h00, 2'b00, 8'h13, 8'h20, 8'h00, 8'h01);
    wait_idle();
    chk("t6_reinit_done", 32'(init_done), 32'h1);

    // reserved op: no bus activity, immediate response
    wr_log.delete(); re_log.delete();
    send(2'b11, 1'b0, 8'h00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_idle();
    chk("rsv_bus", 32'(wr_log.size() + re_log.size()), 32'd0);
    chk("rsv_latency", 32'(last_lat), 32'd1);

    for (int k = 0; k < 200; k++) begin
      send(2'($urandom), 1'($urandom), 8'($urandom), 2'($urandom),
           8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 1) == 1) wait_idle();
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
